// File: rtl/if_stage_pkg.sv
// Shared IF-stage constants and types: bus widths, reset PC and BTB entry layout.
// The optional branch target buffer is compiled in by defining IF_BTB_EN.
package if_stage_pkg;

  localparam int IF_TO_IPD_BUS_WD = 96;
  localparam int ID_TO_IF_BUS_WD  = 33;
  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  localparam int BTB_ENTRIES = 4;
  localparam int BTB_IDX_W   = 2;
  localparam int BTB_TAG_W   = 28;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_btb.sv
// Four-entry direct-mapped branch target buffer: index PC[3:2], tag PC[31:4].
// Lookup is combinational; an update in the same cycle becomes visible next cycle.
module if_btb
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic [31:0] lookup_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target
);

  logic                 valid_reg  [BTB_ENTRIES];
  logic [BTB_TAG_W-1:0] tag_reg    [BTB_ENTRIES];
  logic [31:0]          target_reg [BTB_ENTRIES];

  logic [BTB_IDX_W-1:0] lookup_idx;
  logic [BTB_IDX_W-1:0] upd_idx;
  btb_entry_t           rd_entry;
  logic                 unused_pc_bits;

  assign lookup_idx     = lookup_pc[3:2];
  assign upd_idx        = upd_pc[3:2];
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (upd_en && upd_idx == gi[BTB_IDX_W-1:0]) begin
          valid_reg[gi] <= 1'b1;
        end
      end

      // Tag/target need no reset: they are only trusted behind the valid bit.
      always_ff @(posedge clk) begin
        if (upd_en && upd_idx == gi[BTB_IDX_W-1:0]) begin
          tag_reg[gi]    <= upd_pc[31:4];
          target_reg[gi] <= upd_target;
        end
      end
    end
  endgenerate

  assign rd_entry      = '{valid:  valid_reg[lookup_idx],
                           tag:    tag_reg[lookup_idx],
                           target: target_reg[lookup_idx]};
  assign hit           = rd_entry.valid && (rd_entry.tag == lookup_pc[31:4]);
  assign lookup_target = rd_entry.target;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: holds fetch PC, issues inst RAM reads on handoff to IPD,
// and takes redirects from ID. Define IF_BTB_EN to add BTB-based next-PC prediction.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ID_TO_IF_BUS_WD-1:0]  ID_to_IF_bus,
  input  logic                        IPD_allow_in,
  output logic                        IF_to_IPD_valid,
  output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
  output logic                        inst_ram_en,
  output logic [3:0]                  inst_ram_we,
  output logic [31:0]                 inst_ram_addr,
  output logic [31:0]                 inst_ram_w_data,
  input  logic                        btb_upd_en,
  input  logic [31:0]                 btb_upd_pc,
  input  logic [31:0]                 btb_upd_target
);

  logic        fetch_pc_reg;
  logic [31:0] fetch_pc_q;
  logic [31:0] fetch_pc_next;
  logic        if_valid_reg;
  logic        br_taken_cancel;
  logic [31:0] pc_from_id;
  logic        handoff;
  logic [31:0] pred_pc;

  assign fetch_pc_reg    = 1'b0;
  assign br_taken_cancel = ID_to_IF_bus[32];
  assign pc_from_id      = ID_to_IF_bus[31:0];

`ifdef IF_BTB_EN
  logic        btb_hit;
  logic [31:0] btb_target;

  if_btb u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (fetch_pc_q),
    .hit           (btb_hit),
    .lookup_target (btb_target),
    .upd_en        (btb_upd_en),
    .upd_pc        (btb_upd_pc),
    .upd_target    (btb_upd_target)
  );

  assign pred_pc = btb_hit ? btb_target : next_seq_pc(fetch_pc_q);
`else
  logic unused_btb_upd;

  assign unused_btb_upd = ^{btb_upd_en, btb_upd_pc, btb_upd_target, fetch_pc_reg};
  assign pred_pc        = next_seq_pc(fetch_pc_q);
`endif

  // A cancel kills the wrong-path fetch outright, so it can never hand off.
  assign IF_to_IPD_valid = if_valid_reg & ~br_taken_cancel;
  assign handoff         = IF_to_IPD_valid & IPD_allow_in;

  assign inst_ram_en     = handoff;
  assign inst_ram_we     = 4'b0;
  assign inst_ram_addr   = fetch_pc_q;
  assign inst_ram_w_data = 32'b0;
  assign IF_to_IPD_bus   = {pred_pc, fetch_pc_q, 32'b0};

  always_comb begin
    fetch_pc_next = fetch_pc_q;
    if (br_taken_cancel) begin
      fetch_pc_next = pc_from_id;
    end else if (handoff) begin
      fetch_pc_next = pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      if_valid_reg <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_next;
      if_valid_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: reset, stall, redirects, PC wrap and BTB training.
// Build with IF_BTB_EN defined to exercise the BTB-predicted paths.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [32:0] ID_to_IF_bus;
  logic        IPD_allow_in;
  logic        IF_to_IPD_valid;
  logic [95:0] IF_to_IPD_bus;
  logic        inst_ram_en;
  logic [3:0]  inst_ram_we;
  logic [31:0] inst_ram_addr;
  logic [31:0] inst_ram_w_data;
  logic        btb_upd_en;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;

  int n_checks = 0;
  int n_pass   = 0;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ID_to_IF_bus    (ID_to_IF_bus),
    .IPD_allow_in    (IPD_allow_in),
    .IF_to_IPD_valid (IF_to_IPD_valid),
    .IF_to_IPD_bus   (IF_to_IPD_bus),
    .inst_ram_en     (inst_ram_en),
    .inst_ram_we     (inst_ram_we),
    .inst_ram_addr   (inst_ram_addr),
    .inst_ram_w_data (inst_ram_w_data),
    .btb_upd_en      (btb_upd_en),
    .btb_upd_pc      (btb_upd_pc),
    .btb_upd_target  (btb_upd_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%08h", tag, got);
    end else begin
      $display("FAIL %-14s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Advance one clock, then leave 1 time unit before touching inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes, then check the fetch state.
  task automatic check_if(input string tag, input logic [31:0] addr, input logic valid,
                          input logic en, input logic [31:0] pred);
    #1;
    check({tag, ".addr"},  inst_ram_addr, addr);
    check({tag, ".valid"}, {31'b0, IF_to_IPD_valid}, {31'b0, valid});
    check({tag, ".en"},    {31'b0, inst_ram_en}, {31'b0, en});
    check({tag, ".pred"},  IF_to_IPD_bus[95:64], pred);
  endtask

  initial begin
    reset          = 1'b1;
    ID_to_IF_bus   = '0;
    IPD_allow_in   = 1'b0;
    btb_upd_en     = 1'b0;
    btb_upd_pc     = '0;
    btb_upd_target = '0;

    repeat (3) cyc();
    check_if("reset", 32'h1C00_0000, 1'b0, 1'b0, 32'h1C00_0004);
    check("reset.we", {28'b0, inst_ram_we}, 32'h0);

    reset        = 1'b0;
    IPD_allow_in = 1'b1;
    cyc();
    check_if("boot0", 32'h1C00_0000, 1'b1, 1'b1, 32'h1C00_0004);
    check("boot0.instpc", IF_to_IPD_bus[63:32], 32'h1C00_0000);
    check("boot0.low",    IF_to_IPD_bus[31:0],  32'h0);
    check("boot0.wdata",  inst_ram_w_data,      32'h0);
    cyc();
    check_if("boot1", 32'h1C00_0004, 1'b1, 1'b1, 32'h1C00_0008);

    // Four-cycle stall at 0x1C000008.
    cyc();
    IPD_allow_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_if("stall", 32'h1C00_0008, 1'b1, 1'b0, 32'h1C00_000C);
      if (i < 3) cyc();
    end
    IPD_allow_in = 1'b1;
    check_if("unstall", 32'h1C00_0008, 1'b1, 1'b1, 32'h1C00_000C);
    cyc();
    check_if("after_stall", 32'h1C00_000C, 1'b1, 1'b1, 32'h1C00_0010);

    // Redirect while IPD accepts: the wrong-path fetch is dropped.
    ID_to_IF_bus = {1'b1, 32'h1C00_0100};
    check_if("redir_allow", 32'h1C00_000C, 1'b0, 1'b0, 32'h1C00_0010);
    cyc();
    ID_to_IF_bus = '0;
    check_if("redir_tgt", 32'h1C00_0100, 1'b1, 1'b1, 32'h1C00_0104);
    cyc();

    // Redirect during stall: takes effect immediately, then exactly one handoff.
    IPD_allow_in = 1'b0;
    ID_to_IF_bus = {1'b1, 32'h1C00_0200};
    check_if("redir_stall", 32'h1C00_0104, 1'b0, 1'b0, 32'h1C00_0108);
    cyc();
    ID_to_IF_bus = '0;
    check_if("rs_hold", 32'h1C00_0200, 1'b1, 1'b0, 32'h1C00_0204);
    IPD_allow_in = 1'b1;
    check_if("rs_go", 32'h1C00_0200, 1'b1, 1'b1, 32'h1C00_0204);
    cyc();
    check_if("rs_next", 32'h1C00_0204, 1'b1, 1'b1, 32'h1C00_0208);

    // Sequential PC wraps modulo 2^32.
    ID_to_IF_bus = {1'b1, 32'hFFFF_FFFC};
    cyc();
    ID_to_IF_bus = '0;
    check_if("wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0000);
    cyc();
    check_if("wrap_zero", 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0004);

    // Reset in the middle of a stalled redirect wins.
    IPD_allow_in = 1'b0;
    ID_to_IF_bus = {1'b1, 32'h1C00_0300};
    reset        = 1'b1;
    cyc();
    ID_to_IF_bus = '0;
    check_if("mid_reset", 32'h1C00_0000, 1'b0, 1'b0, 32'h1C00_0004);
    reset        = 1'b0;
    IPD_allow_in = 1'b1;
    cyc();
    check_if("rst_boot", 32'h1C00_0000, 1'b1, 1'b1, 32'h1C00_0004);

    // BTB training: 0x1C000010 -> 0x1C000040.
    btb_upd_en     = 1'b1;
    btb_upd_pc     = 32'h1C00_0010;
    btb_upd_target = 32'h1C00_0040;
    cyc();
    btb_upd_en = 1'b0;
    cyc();
    cyc();
    cyc();
`ifdef IF_BTB_EN
    check_if("btb_hit", 32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0040);
    cyc();
    check_if("btb_tgt", 32'h1C00_0040, 1'b1, 1'b1, 32'h1C00_0044);
`else
    check_if("no_btb", 32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0014);
    cyc();
    check_if("no_btb_nx", 32'h1C00_0014, 1'b1, 1'b1, 32'h1C00_0018);
`endif

    // Same index, different tag misses; a same-cycle update is seen only next cycle.
    ID_to_IF_bus = {1'b1, 32'h1C00_0110};
    cyc();
    ID_to_IF_bus = '0;
    IPD_allow_in = 1'b0;
    check_if("btb_alias", 32'h1C00_0110, 1'b1, 1'b0, 32'h1C00_0114);
    btb_upd_en     = 1'b1;
    btb_upd_pc     = 32'h1C00_0110;
    btb_upd_target = 32'h1C00_0500;
    check_if("btb_same_cyc", 32'h1C00_0110, 1'b1, 1'b0, 32'h1C00_0114);
    cyc();
    btb_upd_en = 1'b0;
`ifdef IF_BTB_EN
    check_if("btb_updated", 32'h1C00_0110, 1'b1, 1'b0, 32'h1C00_0500);
`else
    check_if("btb_ignored", 32'h1C00_0110, 1'b1, 1'b0, 32'h1C00_0114);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
